// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared defaults for the instruction-fetch stage and a helper that sizes the
// prefetch occupancy counter. No ports.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int WORD_SIZE_DEF        = 32;
  localparam int ADDR_WIDTH_DEF       = 32;
  localparam int RESET_VECTOR_DEF     = 0;
  localparam int PC_STEP_DEF          = 4;
  localparam int FETCH_FIFO_DEPTH_DEF = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory bus, the redirect request and the decode
// handshake of the fetch stage. Signal prefixes (o_/i_) are seen from the
// fetch unit.
//   master : fetch unit side
//   slave  : memory / decode / branch-resolution side
// -----------------------------------------------------------------------------
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH_DEF
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  logic                  o_im_req;
  logic [ADDR_WIDTH-1:0] o_im_addr;
  logic [WORD_SIZE-1:0]  i_im_rdata;
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;
  logic                  o_valid;
  logic [WORD_SIZE-1:0]  o_instr;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  i_ready;
  logic [CW-1:0]         o_count;

  modport master (
    output o_im_req, o_im_addr, o_valid, o_instr, o_pc, o_count,
    input  i_im_rdata, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_im_req, o_im_addr, o_valid, o_instr, o_pc, o_count,
    output i_im_rdata, i_redirect, i_redirect_pc, i_ready
  );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// -----------------------------------------------------------------------------
// fetch_unit_sync_fifo
// Single-clock FIFO with power-of-2 depth; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate flag. Flush clears both
// pointers and takes priority over push and pop.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_push, i_data      write strobe and data
//   i_pop               read strobe (head advances)
//   i_flush             discard all entries
//   o_data              head entry (undefined when empty)
//   o_count             occupancy 0..DEPTH
//   o_full, o_empty     status
// -----------------------------------------------------------------------------
module fetch_unit_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_count = wr_q - rd_q;
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (o_count == (PW+1)'(DEPTH));
  assign o_data  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    do_push = i_push && !o_full && !i_flush;
    do_pop  = i_pop && !o_empty && !i_flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (i_flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the head is only observed when non-empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: issues one request per cycle to a synchronous
// instruction memory (1-cycle read latency) while prefetch credit allows,
// buffers {pc, instr} pairs and presents the oldest pair to decode over a
// valid/ready handshake. A redirect flushes buffered and in-flight fetches
// and restarts fetching at the (aligned) target.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   bus (master)     o_im_req/o_im_addr/i_im_rdata  memory bus
//                    i_redirect/i_redirect_pc       flush + new PC
//                    o_valid/o_instr/o_pc/i_ready   decode handshake
//                    o_count                        prefetch occupancy
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    WORD_SIZE    = WORD_SIZE_DEF,
  parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
  parameter int                    PC_STEP      = PC_STEP_DEF,
  parameter int                    FIFO_DEPTH   = FETCH_FIFO_DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  fetch_unit_if.master bus
);

  localparam int                    CW         = cnt_width(FIFO_DEPTH);
  localparam int                    FW         = ADDR_WIDTH + WORD_SIZE;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(PC_STEP - 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  logic                  pop;
  logic                  push;
  logic                  req;
  logic [CW:0]           credit;
  logic [CW-1:0]         count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         head;

  always_comb begin
    pop    = !fifo_empty && bus.i_ready && !bus.i_redirect;
    // Entries held + the response still on its way, minus what leaves now.
    // A new request is allowed only if its response is guaranteed a slot.
    credit = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    req    = i_rst_n && !bus.i_redirect && (credit < (CW+1)'(FIFO_DEPTH));
    push   = inflight_q && !bus.i_redirect && !fifo_full;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (bus.i_redirect) begin
      fetch_pc_d = bus.i_redirect_pc & ALIGN_MASK;
    end else if (req) begin
      fetch_pc_d    = fetch_pc_q + STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_unit_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (bus.i_redirect),
    .i_data  ({inflight_pc_q, bus.i_im_rdata}),
    .o_data  (head),
    .o_count (count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Head is forced to zero when empty so decode never sees stale storage.
  assign bus.o_im_req  = req;
  assign bus.o_im_addr = fetch_pc_q;
  assign bus.o_valid   = !fifo_empty;
  assign bus.o_count   = count;
  assign bus.o_pc      = fifo_empty ? '0 : head[FW-1 -: ADDR_WIDTH];
  assign bus.o_instr   = fifo_empty ? '0 : head[WORD_SIZE-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_na;
  logic rst_nb;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.WORD_SIZE(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) ifa ();
  fetch_unit_if #(.WORD_SIZE(32), .ADDR_WIDTH(8),  .FIFO_DEPTH(4)) ifb ();

  fetch_unit #(
    .WORD_SIZE(32), .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .PC_STEP(4), .FIFO_DEPTH(4)
  ) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_na),
    .bus     (ifa)
  );

  fetch_unit #(
    .WORD_SIZE(32), .ADDR_WIDTH(8), .RESET_VECTOR(8'h0), .PC_STEP(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_nb),
    .bus     (ifb)
  );

  // Instruction memories: IM[word k] = 0x100 + k; garbage when not requested.
  always @(posedge clk)
    ifa.i_im_rdata <= ifa.o_im_req ? (32'h100 + (ifa.o_im_addr >> 2)) : 32'hDEAD_BEEF;
  always @(posedge clk)
    ifb.i_im_rdata <= ifb.o_im_req ? (32'h100 + {24'h0, ifb.o_im_addr}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    ifa.i_redirect = 1'b0; ifa.i_redirect_pc = '0; ifa.i_ready = 1'b1;
    ifb.i_redirect = 1'b0; ifb.i_redirect_pc = '0; ifb.i_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", ifa.o_valid, 0);
    chk("rst_count", ifa.o_count, 0);
    chk("rst_req",   ifa.o_im_req, 0);
    chk("rst_instr", ifa.o_instr, 0);
    chk("rst_pc",    ifa.o_pc, 0);

    // 1: streaming with i_ready=1
    @(negedge clk); rst_na = 1'b1; #1;
    chk("t1_req0",  ifa.o_im_req, 1);
    chk("t1_addr0", ifa.o_im_addr, 0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); #1;
      chk("t1_req",  ifa.o_im_req, 1);
      chk("t1_addr", ifa.o_im_addr, 64'(4*k));
      if (k >= 2) begin
        chk("t1_valid", ifa.o_valid, 1);
        chk("t1_pc",    ifa.o_pc, 64'(4*(k-2)));
        chk("t1_instr", ifa.o_instr, 64'(32'h100 + k - 2));
        chk("t1_count", ifa.o_count, 1);
      end else begin
        chk("t1_valid_lat", ifa.o_valid, 0);
      end
    end

    // 2: i_ready=0 from reset, fill, then drain
    @(negedge clk); rst_na = 1'b0; ifa.i_ready = 1'b0; #1;
    @(negedge clk); rst_na = 1'b1; #1;
    chk("t2_req0",  ifa.o_im_req, 1);
    chk("t2_addr0", ifa.o_im_addr, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t2_req",  ifa.o_im_req, 1);
      chk("t2_addr", ifa.o_im_addr, 64'(4*k));
    end
    @(negedge clk); #1;
    chk("t2_stop", ifa.o_im_req, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("t2_stop_full", ifa.o_im_req, 0);
      chk("t2_count4",    ifa.o_count, 4);
      chk("t2_hold_pc",   ifa.o_pc, 0);
      chk("t2_hold_ins",  ifa.o_instr, 32'h100);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); ifa.i_ready = 1'b1; #1;
      chk("t2_pop_pc",    ifa.o_pc, 64'(4*k));
      chk("t2_pop_instr", ifa.o_instr, 64'(32'h100 + k));
      chk("t2_resume",    ifa.o_im_req, 1);
      chk("t2_res_addr",  ifa.o_im_addr, 64'(16 + 4*k));
      chk("t2_count",     ifa.o_count, (k == 0) ? 64'd4 : 64'd3);
    end

    // 3: redirect to unaligned 0x203 with count=3, inflight=1
    @(negedge clk); ifa.i_redirect = 1'b1; ifa.i_redirect_pc = 32'h203; #1;
    chk("t3_pre_count", ifa.o_count, 3);
    chk("t3_no_req",    ifa.o_im_req, 0);
    @(negedge clk); ifa.i_redirect = 1'b0; #1;
    chk("t3_count0", ifa.o_count, 0);
    chk("t3_valid0", ifa.o_valid, 0);
    chk("t3_req",    ifa.o_im_req, 1);
    chk("t3_addr",   ifa.o_im_addr, 32'h200);
    @(negedge clk); #1;
    chk("t3_no_stale", ifa.o_valid, 0);
    chk("t3_addr2",    ifa.o_im_addr, 32'h204);
    @(negedge clk); #1;
    chk("t3_valid", ifa.o_valid, 1);
    chk("t3_pc",    ifa.o_pc, 32'h200);
    chk("t3_instr", ifa.o_instr, 32'h180);

    // 4: redirect beats pop; three back-to-back redirects
    @(negedge clk); ifa.i_redirect = 1'b1; ifa.i_redirect_pc = 32'h10; #1;
    chk("t4_head_valid", ifa.o_valid, 1);
    chk("t4_head_pc",    ifa.o_pc, 32'h204);
    chk("t4_no_req",     ifa.o_im_req, 0);
    @(negedge clk); ifa.i_redirect_pc = 32'h20; #1;
    chk("t4_flushed", ifa.o_valid, 0);
    chk("t4_count0",  ifa.o_count, 0);
    chk("t4_no_req2", ifa.o_im_req, 0);
    @(negedge clk); ifa.i_redirect_pc = 32'h30; #1;
    chk("t4_flushed2", ifa.o_valid, 0);
    @(negedge clk); ifa.i_redirect = 1'b0; #1;
    chk("t4_req",  ifa.o_im_req, 1);
    chk("t4_addr", ifa.o_im_addr, 32'h30);
    @(negedge clk); #1;
    chk("t4_lat", ifa.o_valid, 0);
    @(negedge clk); #1;
    chk("t4_pc0",    ifa.o_pc, 32'h30);
    chk("t4_instr0", ifa.o_instr, 32'h10C);
    @(negedge clk); #1;
    chk("t4_pc1",    ifa.o_pc, 32'h34);
    chk("t4_instr1", ifa.o_instr, 32'h10D);

    // 6: async reset pulse mid-stream with count=2
    @(negedge clk); ifa.i_ready = 1'b0; #1;
    chk("t6_pc", ifa.o_pc, 32'h38);
    @(negedge clk); #1;
    chk("t6_count2", ifa.o_count, 2);
    rst_na = 1'b0; #1;
    chk("t6_async_valid", ifa.o_valid, 0);
    chk("t6_async_count", ifa.o_count, 0);
    chk("t6_async_req",   ifa.o_im_req, 0);
    rst_na = 1'b1; #1;
    chk("t6_req",  ifa.o_im_req, 1);
    chk("t6_addr", ifa.o_im_addr, 0);
    @(negedge clk); #1;
    chk("t6_addr1", ifa.o_im_addr, 4);
    chk("t6_lat",   ifa.o_valid, 0);
    @(negedge clk); #1;
    chk("t6_pc0",    ifa.o_pc, 0);
    chk("t6_instr0", ifa.o_instr, 32'h100);
    chk("t6_count1", ifa.o_count, 1);

    // 5: word addressing, 8-bit PC wrap
    @(negedge clk); rst_nb = 1'b1; ifb.i_redirect = 1'b1; ifb.i_redirect_pc = 8'hFE; #1;
    chk("t5_no_req", ifb.o_im_req, 0);
    @(negedge clk); ifb.i_redirect = 1'b0; #1;
    chk("t5_addr_fe", ifb.o_im_addr, 8'hFE);
    @(negedge clk); #1;
    chk("t5_addr_ff", ifb.o_im_addr, 8'hFF);
    @(negedge clk); #1;
    chk("t5_addr_00", ifb.o_im_addr, 8'h00);
    chk("t5_pc_fe",   ifb.o_pc, 8'hFE);
    chk("t5_in_fe",   ifb.o_instr, 32'h1FE);
    @(negedge clk); #1;
    chk("t5_pc_ff", ifb.o_pc, 8'hFF);
    chk("t5_in_ff", ifb.o_instr, 32'h1FF);
    @(negedge clk); #1;
    chk("t5_pc_00", ifb.o_pc, 8'h00);
    chk("t5_in_00", ifb.o_instr, 32'h100);
    @(negedge clk); #1;
    chk("t5_pc_01", ifb.o_pc, 8'h01);
    chk("t5_in_01", ifb.o_instr, 32'h101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
